// File: rtl/dco_meas_pkg.sv
// Shared types and defaults for the DCO frequency meter: FSM state encoding,
// default parameter values and a counter-width helper.
package dco_meas_pkg;

    localparam int DEF_GATE_CYCLES = 1024;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } meas_state_e;

    // Bits needed for a counter that steps through 0..n-1 (never narrower than 1).
    function automatic int timer_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dco_sync.sv
// Brings the free-running DCO output into the clk domain and emits a one-cycle
// pulse for every rising edge seen after the synchronizer.
module dco_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dco_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    // NOTE: clocked state uses non-blocking assignments so each flop in the chain captures its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], dco_i};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/dco_freq_meter.sv
// Counts synchronized DCO rising edges over a fixed gate window of clk cycles
// and publishes the (saturating) result with a one-cycle valid strobe.
module dco_freq_meter
    import dco_meas_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             dco_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int TMR_W = timer_w(GATE_CYCLES);
    localparam int ARM_W = timer_w(SYNC_STAGES + 1);

    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("dco_freq_meter: GATE_CYCLES must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("dco_freq_meter: SYNC_STAGES must be at least 2");
    end

    logic rise;

    dco_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .dco_i (dco_in),
        .rise_o(rise)
    );

    meas_state_e      state_q,    state_d;
    logic [ARM_W-1:0] arm_q,      arm_d;
    logic [TMR_W-1:0] timer_q,    timer_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_q,      ovf_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;
    logic             valid_q,    valid_d;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        arm_d      = '0;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || continuous) state_d = ST_ARM;
            end
            ST_ARM: begin
                // Hold the measurement state clear while stale synchronizer contents drain.
                timer_d    = '0;
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
                if (arm_q == ARM_LAST) state_d = ST_GATE;
                else                   arm_d   = arm_q + ARM_W'(1);
            end
            ST_GATE: begin
                if (rise) begin
                    if (edge_cnt_q == CNT_MAX) ovf_d      = 1'b1;
                    else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
                if (timer_q == GATE_LAST) state_d = ST_DONE;
                else                      timer_d = timer_q + TMR_W'(1);
            end
            ST_DONE: begin
                state_d = continuous ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!ena) state_d = ST_IDLE;

        // The result includes any rise in the final gate cycle, hence the _d values.
        if (state_q == ST_GATE && state_d == ST_DONE) begin
            count_d    = edge_cnt_d;
            overflow_d = ovf_d;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arm_q      <= '0;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign count_out   = count_q;
    assign overflow    = overflow_q;
    assign count_valid = valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dco_freq_meter.sv
// Scoreboard bench for dco_freq_meter: a default instance and a CNT_W=8 instance
// share one DCO waveform; expected results come from counting 0->1 transitions.
module tb_dco_freq_meter;

    localparam int G      = 1024;
    localparam int S      = 2;
    localparam int W      = 16;
    localparam int W8     = 8;
    localparam int PERIOD = S + G + 2;
    localparam int MAXCYC = 65536;

    typedef struct {
        int due;
        int count;
        bit ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          dco_in = 1'b0;
    logic          start_a = 1'b0, cont_a = 1'b0;
    logic          start_b = 1'b0, cont_b = 1'b0;
    logic [W-1:0]  count_a;
    logic [W8-1:0] count_b;
    logic          valid_a, busy_a, ovf_a;
    logic          valid_b, busy_b, ovf_b;

    bit   wave [MAXCYC];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    dco_freq_meter u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .dco_in(dco_in),
        .start(start_a), .continuous(cont_a),
        .count_out(count_a), .count_valid(valid_a), .busy(busy_a), .overflow(ovf_a)
    );

    dco_freq_meter #(.CNT_W(W8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .dco_in(dco_in),
        .start(start_b), .continuous(cont_b),
        .count_out(count_b), .count_valid(valid_b), .busy(busy_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // cyc holds the index of the most recent rising edge; wave[k] is the level sampled at edge k.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) dco_in = (cyc + 1 < MAXCYC) ? wave[cyc + 1] : 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Start sampled at edge p: the gate sees rising transitions of the sampled
    // input landing on edges p+2 .. p+G+1, and the strobe appears at edge p+S+G+1.
    function automatic exp_t model(input int p, input int w);
        exp_t e;
        int   rises = 0;
        int   maxv  = (1 << w) - 1;
        for (int j = p + 2; j <= p + G + 1; j++)
            if (wave[j] && !wave[j - 1]) rises++;
        e.due   = p + S + G + 1;
        e.count = (rises > maxv) ? maxv : rises;
        e.ovf   = (rises > maxv);
        return e;
    endfunction

    task automatic push_a(input int p);
        exp_t e = model(p, W);
        q_a.push_back(e);
        last_a = e.count;
    endtask

    // hi==0: constant 0; lo==0: constant 1; otherwise hi/lo periodic with random phase.
    task automatic fill(input int n, input int hi, input int lo, input int noise);
        int base = cyc + 2;
        int ph   = $urandom_range(0, 63);
        for (int k = 0; k < n; k++) begin
            bit v;
            if (hi == 0)      v = 1'b0;
            else if (lo == 0) v = 1'b1;
            else              v = ((k + ph) % (hi + lo)) < hi;
            if (noise > 0 && $urandom_range(0, 99) < noise) v = ~v;
            if (base + k < MAXCYC) wave[base + k] = v;
        end
    endtask

    task automatic do_start(input bit use_a, input bit use_b, input bit expect_res, output int p);
        @(negedge clk);
        p       = cyc + 1;
        start_a = use_a;
        start_b = use_b;
        if (expect_res) begin
            if (use_a) push_a(p);
            if (use_b) q_b.push_back(model(p, W8));
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q_a.size() + q_b.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count_a"}, count_a, 0);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_busy_a"},  busy_a,  0);
        check({tag, "_ovf_a"},   ovf_a,   0);
        check({tag, "_count_b"}, count_b, 0);
        check({tag, "_valid_b"}, valid_b, 0);
        check({tag, "_busy_b"},  busy_b,  0);
        check({tag, "_ovf_b"},   ovf_b,   0);
    endtask

    // Monitor: pops one expectation per strobe; a strobe with nothing queued, or an
    // expectation whose cycle has passed, is reported.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_a) begin
                if (q_a.size() == 0) check("spurious_strobe_a", valid_a, 0);
                else begin
                    e = q_a.pop_front();
                    check("latency_a",  cyc,     e.due);
                    check("count_a",    count_a, e.count);
                    check("overflow_a", ovf_a,   e.ovf);
                end
            end else if (q_a.size() != 0 && q_a[0].due < cyc) begin
                check("missing_strobe_a", valid_a, 1);
                void'(q_a.pop_front());
            end
            if (valid_b) begin
                if (q_b.size() == 0) check("spurious_strobe_b", valid_b, 0);
                else begin
                    e = q_b.pop_front();
                    check("latency_b",  cyc,     e.due);
                    check("count_b",    count_b, e.count);
                    check("overflow_b", ovf_b,   e.ovf);
                end
            end else if (q_b.size() != 0 && q_b[0].due < cyc) begin
                check("missing_strobe_b", valid_b, 1);
                void'(q_b.pop_front());
            end
        end
    end

    initial begin
        int p;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (2) @(negedge clk);

        // Period 4 (2 hi / 2 lo): 256 on the wide counter, saturated on the narrow one.
        fill(G + S + 64, 2, 2, 0);
        do_start(1'b1, 1'b1, 1'b1, p);
        check("busy_after_start", busy_a, 1);
        wait_drain(PERIOD + 8);

        // Held low, then held high: no edges either way.
        fill(G + S + 64, 0, 1, 0);
        do_start(1'b1, 1'b1, 1'b1, p);
        wait_drain(PERIOD + 8);
        fill(G + S + 64, 1, 0, 0);
        do_start(1'b1, 1'b1, 1'b1, p);
        wait_drain(PERIOD + 8);

        // Period 2 on the 8-bit instance: 512 edges saturate at 255 with overflow.
        fill(G + S + 64, 1, 1, 0);
        do_start(1'b0, 1'b1, 1'b1, p);
        wait_drain(PERIOD + 8);

        // Continuous, period 8: back-to-back strobes, then continuous dropped mid-run.
        fill(4 * PERIOD + 64, 4, 4, 0);
        do_start(1'b1, 1'b0, 1'b1, p);
        cont_a = 1'b1;
        push_a(p + PERIOD);
        push_a(p + 2 * PERIOD);
        wait_cyc(p + 2 * PERIOD + 500);
        cont_a = 1'b0;
        wait_drain(3 * PERIOD);
        wait_cyc(p + 3 * PERIOD + 50);
        check("idle_after_continuous", busy_a, 0);

        // ena dropped 300 cycles into the gate: abort, no strobe, result held.
        fill(G + S + 64, 3, 5, 0);
        do_start(1'b1, 1'b0, 1'b0, p);
        wait_cyc(p + S + 1 + 300);
        ena = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_a, 0);
        check("abort_hold_count", count_a, last_a);
        wait_cyc(p + PERIOD + 20);
        check("abort_still_held", count_a, last_a);
        ena = 1'b1;
        repeat (2) @(negedge clk);

        // start while busy is ignored: exactly one result.
        fill(G + S + 64, 5, 3, 0);
        do_start(1'b1, 1'b0, 1'b1, p);
        wait_cyc(p + S + 1 + 100);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_drain(PERIOD + 8);
        wait_cyc(p + 2 * PERIOD + 10);
        check("no_extra_measurement", busy_a, 0);

        // Asynchronous reset mid-gate, then a fresh measurement.
        fill(G + S + 64, 2, 2, 0);
        do_start(1'b1, 1'b1, 1'b0, p);
        wait_cyc(p + S + 1 + 400);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill(G + S + 64, 6, 2, 0);
        do_start(1'b1, 1'b1, 1'b1, p);
        wait_drain(PERIOD + 8);

        // Randomized waveforms, including noise and constant levels.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            fill(G + S + 64, $urandom_range(1, 12), $urandom_range(0, 12), $urandom_range(0, 15));
            do_start(1'b1, 1'b1, 1'b1, p);
            wait_drain(PERIOD + 8);
        end

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
